// File: rtl/fifo_seq_chk_pkg.sv
// ============================================================================
// Module   : fifo_seq_chk_pkg
// Brief    : Shared constants for the FIFO read-side sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_seq_chk_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACQUIRE = 2'd1;
   localparam logic [1:0] TRACK   = 2'd2;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] c_lfsr_tap_mask = 16'hB400;

   localparam int c_def_w          = 32;
   localparam int c_def_err_cnt_w  = 16;
   localparam int c_def_word_cnt_w = 32;
   localparam int c_bad_cnt_w      = 4;

endpackage

`default_nettype wire

// File: rtl/fifo_seq_checker_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clr has priority over inc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_seq_checker.sv
// ============================================================================
// Module   : fifo_seq_checker
// Brief    : Drains an async FIFO and checks the data is a mod-2^W increment.
//            Define FIFO_SEQ_CHK_THROTTLE_EN to gate reads with an LFSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_seq_checker
   import fifo_seq_chk_pkg::*;
#(
   parameter int          W             = c_def_w,
   parameter int          ERR_CNT_W     = c_def_err_cnt_w,
   parameter int          WORD_CNT_W    = c_def_word_cnt_w,
   parameter int          RELOCK_THRESH = 4,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  rd_empty,
   output logic                  rd_en,
   input  logic [W-1:0]          dout,
   output logic                  locked,
   output logic                  fifo_error,
   output logic                  err_sticky,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [WORD_CNT_W-1:0] word_count,
   output logic [W-1:0]          first_bad_exp,
   output logic [W-1:0]          first_bad_act
);

   localparam logic [c_bad_cnt_w-1:0] c_relock_last = c_bad_cnt_w'(RELOCK_THRESH - 1);

   logic [1:0]             r_state;
   logic                   r_rd_en_d;
   logic [W-1:0]           r_expected;
   logic                   r_locked;
   logic                   r_fifo_error;
   logic                   r_err_sticky;
   logic [W-1:0]           r_first_exp;
   logic [W-1:0]           r_first_act;
   logic [c_bad_cnt_w-1:0] w_bad_cnt;
   logic                   w_throttle;
   logic                   w_check;
   logic                   w_mismatch;
   logic                   w_match;
   logic                   w_relock;

`ifdef FIFO_SEQ_CHK_THROTTLE_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & c_lfsr_tap_mask)};
      end
   end

   assign w_throttle = r_lfsr[0];
`else
   logic w_unused_seed;
   assign w_unused_seed = ^LFSR_SEED;
   assign w_throttle    = 1'b1;
`endif

   assign rd_en      = enable & ~rd_empty & ~rst & (r_state != IDLE) & w_throttle;

   // A word arriving in TRACK is checked even if enable has just dropped
   assign w_check    = r_rd_en_d & (r_state == TRACK);
   assign w_mismatch = w_check & (dout != r_expected);
   assign w_match    = w_check & (dout == r_expected);
   assign w_relock   = w_mismatch & (w_bad_cnt == c_relock_last);

   sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (w_mismatch),
      .count (err_count)
   );

   sat_counter #(.WIDTH(WORD_CNT_W)) u_word_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (w_check),
      .count (word_count)
   );

   sat_counter #(.WIDTH(c_bad_cnt_w)) u_bad_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_match | w_relock),
      .inc   (w_mismatch),
      .count (w_bad_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rd_en_d    <= 1'b0;
         r_expected   <= '0;
         r_locked     <= 1'b0;
         r_fifo_error <= 1'b0;
         r_err_sticky <= 1'b0;
         r_first_exp  <= '0;
         r_first_act  <= '0;
      end else begin
         r_rd_en_d <= rd_en;

         if (w_check) begin
            r_fifo_error <= w_mismatch;
            r_expected   <= dout + 1'b1;
         end

         if (clear) begin
            r_err_sticky <= 1'b0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
         end else if (w_mismatch) begin
            r_err_sticky <= 1'b1;
            if (!r_err_sticky) begin
               r_first_exp <= r_expected;
               r_first_act <= dout;
            end
         end

         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state <= ACQUIRE;
               end
            end
            ACQUIRE: begin
               if (!enable) begin
                  r_state  <= IDLE;
                  r_locked <= 1'b0;
               end else if (r_rd_en_d) begin
                  r_expected <= dout + 1'b1;
                  r_locked   <= 1'b1;
                  r_state    <= TRACK;
               end
            end
            TRACK: begin
               if (!enable) begin
                  r_state  <= IDLE;
                  r_locked <= 1'b0;
               end else if (w_relock) begin
                  r_state  <= ACQUIRE;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign locked        = r_locked;
   assign fifo_error    = r_fifo_error;
   assign err_sticky    = r_err_sticky;
   assign first_bad_exp = r_first_exp;
   assign first_bad_act = r_first_act;

endmodule

`default_nettype wire

// File: tb/tb_fifo_seq_checker.sv
// ============================================================================
// Module   : tb_fifo_seq_checker
// Brief    : Self-checking bench: FIFO model, reference checker, directed steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_seq_checker;

   localparam int W    = 32;
   localparam int ECW  = 16;
   localparam int WCW  = 32;
   localparam int THR  = 4;
   localparam longint EMAX = (64'd1 << ECW) - 1;
   localparam longint WMAX = (64'd1 << WCW) - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           enable = 1'b0;
   logic           clear = 1'b0;
   logic           rd_empty = 1'b1;
   logic           rd_en;
   logic [W-1:0]   dout = '0;
   logic           locked;
   logic           fifo_error;
   logic           err_sticky;
   logic [ECW-1:0] err_count;
   logic [WCW-1:0] word_count;
   logic [W-1:0]   first_bad_exp;
   logic [W-1:0]   first_bad_act;

   always #10 clk = ~clk;

   fifo_seq_checker #(
      .W             (W),
      .ERR_CNT_W     (ECW),
      .WORD_CNT_W    (WCW),
      .RELOCK_THRESH (THR),
      .LFSR_SEED     (16'hACE1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .clear         (clear),
      .rd_empty      (rd_empty),
      .rd_en         (rd_en),
      .dout          (dout),
      .locked        (locked),
      .fifo_error    (fifo_error),
      .err_sticky    (err_sticky),
      .err_count     (err_count),
      .word_count    (word_count),
      .first_bad_exp (first_bad_exp),
      .first_bad_act (first_bad_act)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] q[$];
   bit           hold_empty = 1'b0;
   bit           fire       = 1'b0;
   bit           pend_valid = 1'b0;

   // Reference checker: phase 0 = parked, 1 = hunting for a seed, 2 = following
   int           m_phase;
   bit           m_locked, m_ferr, m_sticky;
   longint       m_errs, m_words;
   int           m_run;
   logic [W-1:0] m_exp, m_fexp, m_fact;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_locked = 0; m_ferr = 0; m_sticky = 0;
      m_errs = 0; m_words = 0; m_run = 0;
      m_exp = '0; m_fexp = '0; m_fact = '0;
   endtask

   task automatic model_edge(input bit valid, input logic [W-1:0] d);
      int p;
      bit relock;
      p = m_phase;
      relock = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (valid && p == 2) begin
         m_words = (m_words < WMAX) ? m_words + 1 : WMAX;
         if (d !== m_exp) begin
            m_ferr = 1;
            m_errs = (m_errs < EMAX) ? m_errs + 1 : EMAX;
            if (!m_sticky) begin
               m_fexp = m_exp;
               m_fact = d;
            end
            m_sticky = 1;
            m_run++;
            if (m_run == THR) begin
               relock = 1;
               m_run = 0;
            end
         end else begin
            m_ferr = 0;
            m_run = 0;
         end
         m_exp = d + 1;
      end else if (valid && p == 1 && enable) begin
         m_exp = d + 1;
         m_locked = 1;
         m_phase = 2;
      end
      if (clear) begin
         m_errs = 0; m_words = 0; m_sticky = 0; m_fexp = '0; m_fact = '0;
      end
      if (!enable) begin
         if (p != 0) begin
            m_phase = 0;
            m_locked = 0;
         end
      end else if (p == 0) begin
         m_phase = 1;
      end else if (relock) begin
         m_phase = 1;
         m_locked = 0;
      end
   endtask

   task automatic check_all();
      chk("locked", 64'(locked), 64'(m_locked));
      chk("fifo_error", 64'(fifo_error), 64'(m_ferr));
      chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
      chk("err_count", 64'(err_count), m_errs);
      chk("word_count", 64'(word_count), m_words);
      chk("first_bad_exp", 64'(first_bad_exp), 64'(m_fexp));
      chk("first_bad_act", 64'(first_bad_act), 64'(m_fact));
   endtask

   // One clock: inputs are set at the falling edge, outputs checked just after the rising edge
   task automatic cycle();
      bit           exp_rd;
      bit           v_now;
      logic [W-1:0] d_now;
      rd_empty = hold_empty || (q.size() == 0);
      #1;
      exp_rd = enable && !rd_empty && (m_phase != 0) && !rst;
      fire = rd_en;
`ifdef FIFO_SEQ_CHK_THROTTLE_EN
      chk("rd_en_gated", 64'(fire & ~exp_rd), 64'd0);
`else
      chk("rd_en", 64'(fire), 64'(exp_rd));
`endif
      @(posedge clk);
      #1;
      v_now = pend_valid;
      d_now = dout;
      model_edge(v_now, d_now);
      pend_valid = fire;
      if (fire && q.size() != 0) dout = q.pop_front();
      else dout = $urandom();
      check_all();
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q.size() != 0 || pend_valid) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", 64'(n < budget), 64'd1);
      cycle();
      cycle();
   endtask

   task automatic do_reset();
      q.delete();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
   endtask

   initial begin
      logic [W-1:0] prev, r, x, base;
      int           n;
      int           fires;
      model_reset();
      @(negedge clk);

      // Reset state
      do_reset();
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
      chk("rst_first_bad_act", 64'(first_bad_act), 64'd0);

      // 64-word incrementing stream
      enable = 1;
      for (int i = 1; i <= 64; i++) q.push_back(32'hFFFFFF00 + i);
      drain(500);
      chk("seq_locked", 64'(locked), 64'd1);
      chk("seq_word_count", 64'(word_count), 64'd63);
      chk("seq_err_count", 64'(err_count), 64'd0);
      chk("seq_fifo_error", 64'(fifo_error), 64'd0);

      // Wrap-around through zero
      do_reset();
      q.push_back(32'hFFFFFFFE); q.push_back(32'hFFFFFFFF);
      q.push_back(32'h00000000); q.push_back(32'h00000001);
      drain(100);
      chk("wrap_word_count", 64'(word_count), 64'd3);
      chk("wrap_err_count", 64'(err_count), 64'd0);
      chk("wrap_sticky", 64'(err_sticky), 64'd0);

      // Single corrupted word gives two mismatches
      do_reset();
      q.push_back(10); q.push_back(11); q.push_back(12);
      q.push_back(99); q.push_back(14); q.push_back(15);
      drain(100);
      chk("bad_err_count", 64'(err_count), 64'd2);
      chk("bad_first_exp", 64'(first_bad_exp), 64'd13);
      chk("bad_first_act", 64'(first_bad_act), 64'd99);
      chk("bad_sticky", 64'(err_sticky), 64'd1);
      chk("bad_fifo_error_after", 64'(fifo_error), 64'd0);
      chk("bad_locked", 64'(locked), 64'd1);
      chk("bad_word_count", 64'(word_count), 64'd5);

      // Clear coinciding with a mismatch (expected is 16 here)
      q.push_back(17);
      n = 0;
      while (!pend_valid && n < 50) begin
         cycle();
         n++;
      end
      chk("clr_word_issued", 64'(pend_valid), 64'd1);
      clear = 1;
      cycle();
      clear = 0;
      chk("clr_err_count", 64'(err_count), 64'd0);
      chk("clr_sticky", 64'(err_sticky), 64'd0);
      chk("clr_fifo_error", 64'(fifo_error), 64'd1);
      chk("clr_first_exp", 64'(first_bad_exp), 64'd0);

      // Relock after THR consecutive mismatches
      do_reset();
      for (int i = 100; i <= 105; i++) q.push_back(i);
      prev = 105;
      for (int i = 0; i < THR; i++) begin
         r = $urandom();
         while (r == prev + 1) r = $urandom();
         q.push_back(r);
         prev = r;
      end
      x = $urandom();
      q.push_back(x);
      q.push_back(x + 1);
      drain(100);
      chk("relock_err_count", 64'(err_count), 64'd4);
      chk("relock_word_count", 64'(word_count), 64'd10);
      chk("relock_locked", 64'(locked), 64'd1);
      chk("relock_fifo_error", 64'(fifo_error), 64'd0);

      // Reset with a read in flight while the FIFO reports empty
      for (int i = 0; i < 4; i++) q.push_back(200 + i);
      n = 0;
      while (!pend_valid && n < 50) begin
         cycle();
         n++;
      end
      hold_empty = 1;
      rst = 1;
      cycle();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rstfly_rd_en", 64'(rd_en), 64'd0);
      end
      chk("rstfly_locked", 64'(locked), 64'd0);
      chk("rstfly_word_count", 64'(word_count), 64'd0);
      chk("rstfly_err_count", 64'(err_count), 64'd0);
      hold_empty = 0;
      q.delete();

      // Randomised traffic: stalls, enable drops, clears, occasional corruption
      do_reset();
      base = $urandom();
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) q.push_back($urandom());
         else q.push_back(base + i);
      end
      n = 0;
      while ((q.size() != 0 || pend_valid) && n < 3000) begin
         enable     = ($urandom_range(0, 9) != 0);
         hold_empty = ($urandom_range(0, 4) == 0);
         clear      = ($urandom_range(0, 49) == 0);
         cycle();
         n++;
      end
      enable = 1; hold_empty = 0; clear = 0;
      chk("rand_in_budget", 64'(n < 3000), 64'd1);
      cycle();

`ifdef FIFO_SEQ_CHK_THROTTLE_EN
      do_reset();
      enable = 1;
      for (int i = 0; i < 1100; i++) q.push_back(i);
      fires = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle();
         fires += int'(fire);
      end
      chk("duty_in_range", 64'(fires >= 400 && fires <= 600), 64'd1);
      q.delete();
`else
      fires = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_seq_checker.md
Name: fifo_seq_checker

Overview:
- Read-side consumer for the async BRAM FIFO. Drains the FIFO whenever data is available, then checks that the data forms a modular-incrementing sequence.
- Reports per-word and sticky errors, error and word statistics, and the first mismatching pair, so on-board FIFO soak tests can be read from one block.
- Sits in the FIFO read clock domain, directly on the FIFO rd_en/dout/rd_empty port. The FIFO has 1-cycle read latency.

Parameters:
- W, 32, data width; must match FIFO dout width.
- ERR_CNT_W, 16, width of the saturating error counter.
- WORD_CNT_W, 32, width of the saturating checked-word counter.
- RELOCK_THRESH, 4, number of consecutive mismatches that drops lock and forces re-acquire; range 1..15.
- LFSR_SEED, 16'hACE1, non-zero seed for the throttle LFSR (used only with the optional feature).

Ports:
- clk  input  1  read-domain clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  allow reads; 0 parks the block in IDLE
- clear  input  1  single-cycle pulse; zeroes statistics and captures
- rd_empty  input  1  FIFO empty flag
- rd_en  output  1  FIFO read strobe
- dout  input  W  FIFO read data, valid the cycle after rd_en
- locked  output  1  sequence acquired
- fifo_error  output  1  last checked word mismatched
- err_sticky  output  1  any mismatch since reset or clear
- err_count  output  ERR_CNT_W  mismatches, saturating
- word_count  output  WORD_CNT_W  words checked in TRACK, saturating
- first_bad_exp  output  W  expected value at first mismatch
- first_bad_act  output  W  actual value at first mismatch

Behaviour:
- Reset values: all outputs 0; state IDLE; rd_en_d 0; expected 0; consecutive-bad count 0.
- rd_en is combinational: enable & ~rd_empty & ~rst & (state != IDLE), further gated by the throttle when that feature is built in.
- rd_en_d is registered from rd_en. When rd_en_d = 1, dout is a valid word ("valid word" below). No read is issued while rst is high.
- State IDLE: wait for enable = 1, then go to ACQUIRE next cycle.
- State ACQUIRE: on the first valid word, set expected <= dout + 1 (mod 2^W), set locked <= 1, go to TRACK. This word is not counted and cannot cause an error.
- State TRACK, valid word equal to expected (match):
  - word_count +1, saturating.
  - fifo_error <= 0.
  - consecutive-bad count <= 0.
- State TRACK, valid word not equal to expected (mismatch):
  - word_count +1, saturating.
  - fifo_error <= 1; err_count +1, saturating at all-ones; err_sticky <= 1.
  - If err_sticky was 0, capture first_bad_exp = expected and first_bad_act = dout.
  - consecutive-bad count +1.
  - When consecutive-bad count reaches RELOCK_THRESH: locked <= 0, go to ACQUIRE, consecutive-bad count <= 0.
- In TRACK, after every valid word, expected <= dout + 1. The checker therefore re-aligns to the observed data: one corrupted word produces exactly 2 mismatches.
- Wrap-around: arithmetic is modulo 2^W. expected = 0xFFFFFFFF followed by dout = 0x00000000 is a match.
- enable deasserted in ACQUIRE or TRACK: rd_en drops in the same cycle; the state goes to IDLE and locked <= 0. A word already in flight (rd_en_d = 1) is still checked against TRACK rules in that cycle. Statistics are retained.
- clear: zeroes err_count, word_count, err_sticky, first_bad_exp and first_bad_act. It does not change state, locked, expected or fifo_error.
- clear on the same cycle as a mismatch: clear wins for counters, sticky and captures; fifo_error still goes to 1.
- rst mid-operation: everything returns to reset values on the next edge. An outstanding FIFO read is discarded.

Optional Feature:
- Macro: FIFO_SEQ_CHK_THROTTLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on rst, advances every cycle.
  - rd_en is additionally ANDed with lfsr[0], giving roughly 50% read duty. This fills the FIFO to exercise the writer's almost-full throttling.
  - Checking rules are unchanged.
- Undefined: no LFSR logic; rd_en is not throttled.

Decomposition:
- Package fifo_seq_chk_pkg holds:
  - state encoding constants IDLE=2'd0, ACQUIRE=2'd1, TRACK=2'd2;
  - the LFSR tap mask;
  - the default widths.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturating). It is instantiated for err_count, word_count and the consecutive-bad count.

Test Plan:
- Feed 0xFFFFFF01..0xFFFFFF40 with enable = 1 → locked after the first word; word_count = 63; err_count = 0; fifo_error = 0 throughout.
- Sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 → no errors across the wrap; word_count = 3.
- Locked stream 10,11,12,99,14,15 → err_count = 2; first_bad_exp = 13; first_bad_act = 99; err_sticky = 1; fifo_error is 1 on the word 99 and on the word 14, then 0 on the word 15; locked stays 1.
- Locked stream followed by 4 random non-sequential words (RELOCK_THRESH = 4) → locked drops after the 4th; the next word reseeds; the following sequential word matches.
- Assert clear on the same cycle as a mismatch → err_count = 0 and err_sticky = 0 next cycle; fifo_error = 1.
- Hold rd_empty = 1, then pulse rst while a read is in flight → rd_en stays 0; all outputs return to 0; state IDLE. With FIFO_SEQ_CHK_THROTTLE_EN defined, rd_en duty over 1000 cycles is within 40–60%.
